// File: rtl/ex_skid_buffer_pkg.sv
// Shared pipeline definitions for the ID/EX elastic stage: payload defaults,
// the empty-slot instruction and the buffer state encoding.
package ex_skid_buffer_pkg;

    localparam int unsigned DEF_W_INSTR = 32;
    localparam int unsigned DEF_W_PC    = 32;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    typedef enum logic [1:0] {
        StEmpty = 2'd0,
        StOne   = 2'd1,
        StTwo   = 2'd2
    } state_e;

    // Beats held in a given state; the encoding happens to equal the count.
    function automatic logic [1:0] occupancy_of(input state_e st);
        unique case (st)
            StOne:   return 2'd1;
            StTwo:   return 2'd2;
            default: return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/ex_skid_buffer.sv
// Two-entry skid buffer between ID/EX and execute: main slot drives the outputs,
// skid slot absorbs the one beat accepted while in_ready is still catching up.
module ex_skid_buffer
    import ex_skid_buffer_pkg::*;
#(
    parameter int unsigned W_INSTR = DEF_W_INSTR,
    parameter int unsigned W_PC    = DEF_W_PC,
    parameter int unsigned W_STALL = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [W_INSTR-1:0] in_instr,
    input  logic [W_PC-1:0]    in_pc,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [W_INSTR-1:0] out_instr,
    output logic [W_PC-1:0]    out_pc,
    output logic [1:0]         occupancy,
    output logic [W_STALL-1:0] stall_cycles
);

    state_e             state_q, state_d;
    logic [W_INSTR-1:0] main_instr, skid_instr;
    logic [W_PC-1:0]    main_pc, skid_pc;
    logic               accept, consume;
    logic               load_main_in, load_main_skid, load_skid;

    assign accept    = in_valid & in_ready;
    assign consume   = out_valid & out_ready;
    assign out_instr = main_instr;
    assign out_pc    = main_pc;

    always_comb begin
        state_d        = state_q;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        unique case (state_q)
            StEmpty: begin
                if (accept) begin
                    state_d      = StOne;
                    load_main_in = 1'b1;
                end
            end
            StOne: begin
                if (accept && consume) begin
                    load_main_in = 1'b1;
                end else if (accept) begin
                    state_d   = StTwo;
                    load_skid = 1'b1;
                end else if (consume) begin
                    state_d = StEmpty;
                end
            end
            StTwo: begin
                if (consume) begin
                    state_d        = StOne;
                    load_main_skid = 1'b1;
                end
            end
            default: state_d = StEmpty;
        endcase
        // Flush wins over everything, including a beat accepted this cycle.
        if (flush) begin
            state_d = StEmpty;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= StEmpty;
            in_ready     <= 1'b1;
            out_valid    <= 1'b0;
            occupancy    <= 2'd0;
            main_instr   <= W_INSTR'(NOP_INSTR);
            main_pc      <= '0;
            skid_instr   <= '0;
            skid_pc      <= '0;
            stall_cycles <= '0;
        end else begin
            state_q   <= state_d;
            in_ready  <= (state_d != StTwo);
            out_valid <= (state_d != StEmpty);
            occupancy <= occupancy_of(state_d);

            if (state_d == StEmpty) begin
                main_instr <= W_INSTR'(NOP_INSTR);
                main_pc    <= '0;
            end else if (load_main_in) begin
                main_instr <= in_instr;
                main_pc    <= in_pc;
            end else if (load_main_skid) begin
                main_instr <= skid_instr;
                main_pc    <= skid_pc;
            end

            if (flush) begin
                skid_instr <= '0;
                skid_pc    <= '0;
            end else if (load_skid) begin
                skid_instr <= in_instr;
                skid_pc    <= in_pc;
            end

            if (out_valid && !out_ready && (stall_cycles != '1)) begin
                stall_cycles <= stall_cycles + W_STALL'(1);
            end
        end
    end

endmodule

// File: tb/tb_ex_skid_buffer.sv
// Directed bench for ex_skid_buffer: a per-cycle vector table for streaming,
// back-pressure and flush, plus sequences for stall saturation and async reset.
module tb_ex_skid_buffer;

    localparam int unsigned W_STALL = 4;
    localparam logic [31:0] TAG     = 32'hA500_0000;

    typedef struct {
        logic        flush;
        logic        iv;
        logic [31:0] pc;
        logic        ordy;
        logic        exp_ov;
        logic        exp_ir;
        logic [1:0]  exp_occ;
        logic [31:0] exp_pc;
        logic [3:0]  exp_stall;
    } vec_t;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               flush = 1'b0;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic [31:0]        in_instr = '0;
    logic [31:0]        in_pc = '0;
    logic               out_valid;
    logic               out_ready = 1'b0;
    logic [31:0]        out_instr;
    logic [31:0]        out_pc;
    logic [1:0]         occupancy;
    logic [W_STALL-1:0] stall_cycles;

    int n_cmp = 0;
    int n_bad = 0;
    vec_t vecs[18];

    ex_skid_buffer #(
        .W_INSTR(32),
        .W_PC   (32),
        .W_STALL(W_STALL)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_instr    (in_instr),
        .in_pc       (in_pc),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_instr   (out_instr),
        .out_pc      (out_pc),
        .occupancy   (occupancy),
        .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string tag, input logic ov, input logic ir, input logic [1:0] occ,
                           input logic [31:0] pc, input logic [3:0] stall);
        chk({tag, ".out_valid"}, 32'(out_valid), 32'(ov));
        chk({tag, ".in_ready"}, 32'(in_ready), 32'(ir));
        chk({tag, ".occupancy"}, 32'(occupancy), 32'(occ));
        chk({tag, ".out_pc"}, out_pc, pc);
        chk({tag, ".out_instr"}, out_instr, ov ? (TAG | pc) : 32'h0);
        chk({tag, ".stall"}, 32'(stall_cycles), 32'(stall));
    endtask

    task automatic drive(input logic fl, input logic iv, input logic [31:0] pc, input logic ordy);
        flush     = fl;
        in_valid  = iv;
        in_pc     = pc;
        in_instr  = TAG | pc;
        out_ready = ordy;
    endtask

    function automatic vec_t mk(input logic fl, input logic iv, input logic [31:0] pc,
                                input logic ordy, input logic ov, input logic ir,
                                input logic [1:0] occ, input logic [31:0] epc,
                                input logic [3:0] st);
        vec_t v;
        v.flush = fl; v.iv = iv; v.pc = pc; v.ordy = ordy;
        v.exp_ov = ov; v.exp_ir = ir; v.exp_occ = occ; v.exp_pc = epc; v.exp_stall = st;
        return v;
    endfunction

    initial begin
        // Each row: inputs held across one rising edge, expected outputs after it.
        //           fl  iv  pc     rdy   ov  ir  occ  out_pc  stall
        vecs[0]  = mk(0, 1, 32'h00, 1,   1, 1, 1, 32'h00, 0); // stream
        vecs[1]  = mk(0, 1, 32'h04, 1,   1, 1, 1, 32'h04, 0);
        vecs[2]  = mk(0, 1, 32'h08, 1,   1, 1, 1, 32'h08, 0);
        vecs[3]  = mk(0, 0, 32'h00, 1,   0, 1, 0, 32'h00, 0);
        vecs[4]  = mk(0, 1, 32'h10, 0,   1, 1, 1, 32'h10, 0); // back-pressure
        vecs[5]  = mk(0, 1, 32'h14, 0,   1, 0, 2, 32'h10, 1);
        vecs[6]  = mk(0, 1, 32'h18, 0,   1, 0, 2, 32'h10, 2);
        vecs[7]  = mk(0, 1, 32'h18, 0,   1, 0, 2, 32'h10, 3);
        vecs[8]  = mk(0, 1, 32'h18, 1,   1, 1, 1, 32'h14, 3);
        vecs[9]  = mk(0, 1, 32'h18, 1,   1, 1, 1, 32'h18, 3);
        vecs[10] = mk(0, 0, 32'h00, 1,   0, 1, 0, 32'h00, 3);
        vecs[11] = mk(0, 1, 32'h30, 0,   1, 1, 1, 32'h30, 3); // flush in TWO
        vecs[12] = mk(0, 1, 32'h34, 0,   1, 0, 2, 32'h30, 4);
        vecs[13] = mk(1, 1, 32'h20, 0,   0, 1, 0, 32'h00, 5);
        vecs[14] = mk(0, 0, 32'h00, 1,   0, 1, 0, 32'h00, 5);
        vecs[15] = mk(1, 1, 32'h40, 1,   0, 1, 0, 32'h00, 5); // flush drops offer
        vecs[16] = mk(0, 1, 32'h44, 0,   1, 1, 1, 32'h44, 5);
        vecs[17] = mk(1, 0, 32'h00, 1,   0, 1, 0, 32'h00, 5); // flush with consume

        drive(0, 0, 32'h0, 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk_all("reset", 0, 1, 0, 32'h0, 0);
        @(negedge clk);
        chk_all("idle", 0, 1, 0, 32'h0, 0);

        for (int i = 0; i < 18; i++) begin
            drive(vecs[i].flush, vecs[i].iv, vecs[i].pc, vecs[i].ordy);
            @(negedge clk);
            chk_all($sformatf("vec%0d", i), vecs[i].exp_ov, vecs[i].exp_ir, vecs[i].exp_occ,
                    vecs[i].exp_pc, vecs[i].exp_stall);
        end

        // Saturation: restart from reset, park one beat with out_ready low.
        drive(0, 0, 32'h0, 0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        drive(0, 1, 32'h50, 0);
        @(negedge clk);
        chk_all("sat_load", 1, 1, 1, 32'h50, 0);
        drive(0, 0, 32'h0, 0);
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            chk($sformatf("sat_cycle%0d", k), 32'(stall_cycles), (k > 15) ? 32'd15 : 32'(k));
        end

        // Fill to TWO, then assert reset between edges.
        drive(0, 1, 32'h54, 0);
        @(negedge clk);
        chk_all("pre_rst_two", 1, 0, 2, 32'h50, 15);
        drive(0, 0, 32'h0, 0);
        #1 reset = 1'b1;
        #1;
        chk_all("async_rst", 0, 1, 0, 32'h0, 0);
        @(negedge clk);
        reset = 1'b0;
        drive(0, 0, 32'h0, 1);
        @(negedge clk);
        chk_all("post_rst", 0, 1, 0, 32'h0, 0);
        drive(0, 1, 32'h60, 1);
        @(negedge clk);
        chk_all("post_rst_beat", 1, 1, 1, 32'h60, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: bench did not reach the summary by t=%0t", $time);
        $fatal(1);
    end

endmodule
